// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array front end: default sizes, the
// feeder FSM encoding and the control triplet that travels with each vector.
package systolic_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DATA_NUM   = 16;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_LEN_WIDTH  = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } feeder_state_t;

  // Control bits the skew stage delays in lockstep with the data lanes.
  typedef struct packed {
    logic input_valid;
    logic is_init_data;
    logic calc_done;
  } ctrl_t;

endpackage

// File: rtl/systolic_feeder.sv
// Fetches a tile of K vectors from a 1-cycle-latency buffer and streams them,
// unskewed, with the input_valid / is_init_data / calc_done triplet.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DATA_NUM   = DEF_DATA_NUM,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start_i,
  input  logic [ADDR_WIDTH-1:0]                      base_addr_i,
  input  logic [LEN_WIDTH-1:0]                       len_i,
  input  logic                                       init_i,
  input  logic                                       stall_i,
  output logic                                       rd_en_o,
  output logic [ADDR_WIDTH-1:0]                      rd_addr_o,
  input  logic signed [DATA_NUM-1:0][DATA_WIDTH-1:0] rd_data_i,
  output logic signed [DATA_NUM-1:0][DATA_WIDTH-1:0] data_o,
  output logic                                       input_valid_o,
  output logic                                       is_init_data_o,
  output logic                                       calc_done_o,
  output logic                                       busy_o,
  output logic                                       done_o
);

  feeder_state_t         state, state_next;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  rd_cnt;
  logic                  init_q;
  logic                  vld_q, first_q, last_q;
  logic                  accept, rd_issue, last_read;
  ctrl_t                 ctrl;

  assign accept    = (state == ST_IDLE) && start_i;
  assign rd_issue  = (state == ST_READ) && !stall_i;
  assign last_read = rd_issue && (rd_cnt == len_q - LEN_WIDTH'(1));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start_i) state_next = (len_i != '0) ? ST_READ : ST_DONE;
      ST_READ: if (last_read) state_next = ST_WAIT;
      ST_WAIT: state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Command is latched on accept; rd_cnt only advances on cycles a read issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      base_q <= '0;
      len_q  <= '0;
      init_q <= 1'b0;
      rd_cnt <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        base_q <= base_addr_i;
        len_q  <= len_i;
        init_q <= init_i;
        rd_cnt <= '0;
      end else if (rd_issue) begin
        rd_cnt <= rd_cnt + LEN_WIDTH'(1);
      end
    end
  end

  // Tags ride one cycle behind each issued read, aligned with the returned data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      vld_q   <= rd_issue;
      first_q <= rd_issue && (rd_cnt == '0);
      last_q  <= last_read;
    end
  end

  assign ctrl.input_valid  = vld_q;
  assign ctrl.is_init_data = vld_q & first_q & init_q;
  assign ctrl.calc_done    = vld_q & last_q;

  assign rd_en_o        = rd_issue;
  assign rd_addr_o      = (state == ST_READ) ? base_q + ADDR_WIDTH'(rd_cnt) : '0;
  assign data_o         = vld_q ? rd_data_i : '0;
  assign input_valid_o  = ctrl.input_valid;
  assign is_init_data_o = ctrl.is_init_data;
  assign calc_done_o    = ctrl.calc_done;
  assign busy_o         = (state != ST_IDLE);
  assign done_o         = (state == ST_DONE);

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: a buffer model answers reads, expected
// vectors are queued when a read is predicted and popped when input_valid_o rises.
module tb_systolic_feeder;

  localparam int DW = 16;
  localparam int DN = 16;
  localparam int AW = 10;
  localparam int LW = 10;

  typedef struct {
    logic [AW-1:0] addr;
    logic          init;
    logic          last;
  } exp_t;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         start_i;
  logic [AW-1:0]                base_addr_i;
  logic [LW-1:0]                len_i;
  logic                         init_i;
  logic                         stall_i;
  logic                         rd_en_o;
  logic [AW-1:0]                rd_addr_o;
  logic signed [DN-1:0][DW-1:0] rd_data;
  logic signed [DN-1:0][DW-1:0] data_o;
  logic                         input_valid_o;
  logic                         is_init_data_o;
  logic                         calc_done_o;
  logic                         busy_o;
  logic                         done_o;

  int   vectors    = 0;
  int   miscompares = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  systolic_feeder #(
    .DATA_WIDTH(DW), .DATA_NUM(DN), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
    .len_i(len_i), .init_i(init_i), .stall_i(stall_i), .rd_en_o(rd_en_o),
    .rd_addr_o(rd_addr_o), .rd_data_i(rd_data), .data_o(data_o),
    .input_valid_o(input_valid_o), .is_init_data_o(is_init_data_o),
    .calc_done_o(calc_done_o), .busy_o(busy_o), .done_o(done_o)
  );

  function automatic logic [DN-1:0][DW-1:0] buf_word(input logic [AW-1:0] a);
    logic [DN-1:0][DW-1:0] w;
    for (int l = 0; l < DN; l++) w[l] = {4'(l), a, 2'b01};
    return w;
  endfunction

  // Buffer model: 1-cycle read latency, junk on cycles without a read.
  logic [DN-1:0][DW-1:0] junk;
  initial for (int l = 0; l < DN; l++) junk[l] = 16'hBEEF;
  always @(posedge clk) rd_data <= rd_en_o ? buf_word(rd_addr_o) : junk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b1; base_addr_i = 10'h155; len_i = 10'd3;
    init_i = 1'b1; stall_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if ({rd_en_o, input_valid_o, is_init_data_o, calc_done_o, busy_o, done_o} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b want 000000",
               {rd_en_o, input_valid_o, is_init_data_o, calc_done_o, busy_o, done_o});
    end
    vectors++;
    if (rd_addr_o !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_addr: got %h want 000", rd_addr_o);
    end
    vectors++;
    if (data_o !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got %h want 0", data_o);
    end
    start_i = 1'b0;
    rst = 1'b0;
  endtask

  // Drives one command in the current cycle (cycle 0) and checks every cycle
  // through done_cyc+1; returns in cycle done_cyc+1 so a new start can follow.
  task automatic run_tile(input string name, input logic [AW-1:0] base,
                          input logic [LW-1:0] len, input logic init,
                          input logic [31:0] stall_mask, input int done_cyc,
                          input int restart_cyc);
    int            reads;
    logic          exp_rd, prev_rd;
    logic [AW-1:0] exp_addr;
    exp_t          e;
    logic [DN-1:0][DW-1:0] exp_data;
    start_i = 1'b1; base_addr_i = base; len_i = len; init_i = init; stall_i = 1'b0;
    reads = 0; prev_rd = 1'b0;
    for (int c = 1; c <= done_cyc + 1; c++) begin
      @(posedge clk); #1;
      start_i = (c == restart_cyc);
      if (c == restart_cyc) begin
        base_addr_i = base + 10'd100; len_i = 10'd9; init_i = !init;
      end
      stall_i = stall_mask[c];
      #1;
      exp_rd = (reads < int'(len)) && !stall_mask[c];
      vectors++;
      if (rd_en_o !== exp_rd) begin
        miscompares++;
        $display("[TB] FAIL %s rd_en c%0d: got %b want %b", name, c, rd_en_o, exp_rd);
      end
      if (exp_rd) begin
        exp_addr = AW'(int'(base) + reads);
        vectors++;
        if (rd_addr_o !== exp_addr) begin
          miscompares++;
          $display("[TB] FAIL %s rd_addr c%0d: got %h want %h", name, c, rd_addr_o, exp_addr);
        end
        sb_q.push_back('{addr: exp_addr, init: init && (reads == 0),
                         last: (reads == int'(len) - 1)});
        reads++;
      end
      vectors++;
      if (input_valid_o !== prev_rd) begin
        miscompares++;
        $display("[TB] FAIL %s valid c%0d: got %b want %b", name, c, input_valid_o, prev_rd);
      end
      if (prev_rd && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        exp_data = buf_word(e.addr);
        vectors++;
        if (data_o !== exp_data) begin
          miscompares++;
          $display("[TB] FAIL %s data c%0d: got %h want %h", name, c, data_o, exp_data);
        end
        vectors++;
        if ({is_init_data_o, calc_done_o} !== {e.init, e.last}) begin
          miscompares++;
          $display("[TB] FAIL %s init/calc_done c%0d: got %b want %b", name, c,
                   {is_init_data_o, calc_done_o}, {e.init, e.last});
        end
      end else begin
        vectors++;
        if ({data_o, is_init_data_o, calc_done_o} !== '0) begin
          miscompares++;
          $display("[TB] FAIL %s idle_out c%0d: got init=%b done=%b data=%h want zeros",
                   name, c, is_init_data_o, calc_done_o, data_o);
        end
      end
      vectors++;
      if ({busy_o, done_o} !== {c <= done_cyc, c == done_cyc}) begin
        miscompares++;
        $display("[TB] FAIL %s busy/done c%0d: got %b want %b", name, c,
                 {busy_o, done_o}, {c <= done_cyc, c == done_cyc});
      end
      prev_rd = exp_rd;
    end
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s scoreboard: got %0d left want 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_basic();
    run_tile("basic", 10'h010, 10'd4, 1'b1, 32'h0, 6, -1);
  endtask

  task automatic test_stall();
    run_tile("stall", 10'h040, 10'd3, 1'b1, 32'h0000_000C, 7, -1);
  endtask

  task automatic test_edge_len();
    run_tile("len0", 10'h080, 10'd0, 1'b1, 32'h0, 1, -1);
    run_tile("len1", 10'h0A5, 10'd1, 1'b0, 32'h0, 3, -1);
    run_tile("len1_init", 10'h0A6, 10'd1, 1'b1, 32'h0, 3, -1);
  endtask

  task automatic test_wrap();
    run_tile("wrap", 10'h3FE, 10'd4, 1'b0, 32'h0, 6, -1);
  endtask

  task automatic test_back_to_back();
    run_tile("reentry", 10'h200, 10'd5, 1'b1, 32'h0, 7, 3);
    run_tile("after_done", 10'h300, 10'd2, 1'b1, 32'h0000_0004, 5, -1);
  endtask

  task automatic test_reset_mid();
    start_i = 1'b1; base_addr_i = 10'h100; len_i = 10'd8; init_i = 1'b1; stall_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      rst = (c == 3);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    vectors++;
    if ({rd_en_o, input_valid_o, is_init_data_o, calc_done_o, busy_o, done_o} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_ctrl: got %b want 000000",
               {rd_en_o, input_valid_o, is_init_data_o, calc_done_o, busy_o, done_o});
    end
    vectors++;
    if ({rd_addr_o, data_o} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midreset_data: got addr=%h data=%h want zeros", rd_addr_o, data_o);
    end
    run_tile("post_reset", 10'h120, 10'd3, 1'b1, 32'h0, 5, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_edge_len();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
